// File: rtl/writeback_unit.sv
// writeback_unit
//
// Write-side front end of the 32x64-bit register bank. ALU results and load
// results from the memory stage are merged onto the bank's single write port
// (C, Cdata, W). Loads wait in a small FIFO. ALU results always win the port
// and never stall. The block also reports pending writes to the bank read
// addresses A and B, so the issue logic can stall on them.
//
// Parameters:
//   DEPTH     load-result FIFO entries (power of two, >= 2)
//
// Ports:
//   CLK       clock, all state updates on the rising edge
//   RST       synchronous active-high reset
//   aluValid  ALU result present this cycle (never back-pressured)
//   aluReg    ALU destination register
//   aluData   ALU result
//   memValid  load result offered
//   memReady  load accepted when memValid && memReady
//   memReg    load destination register
//   memData   load data
//   A, B      bank read addresses used for the hazard check
//   pendA/B   a write to A/B is still outstanding
//   C         bank write address (registered)
//   Cdata     bank write data (registered)
//   W         bank write enable (registered)
//
// Build option:
//   WB_ZERO_REG_EN  register 31 is XZR. ALU writes to it are dropped, loads
//                   to it are queued dead, and hazards on it are never
//                   reported. Without the macro, register 31 is ordinary.

module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        aluValid,
  input  logic [4:0]  aluReg,
  input  logic [63:0] aluData,
  input  logic        memValid,
  output logic        memReady,
  input  logic [4:0]  memReg,
  input  logic [63:0] memData,
  input  logic [4:0]  A,
  input  logic [4:0]  B,
  output logic        pendA,
  output logic        pendB,
  output logic [4:0]  C,
  output logic [63:0] Cdata,
  output logic        W
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]       r_reg  [DEPTH];
  logic [63:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [4:0]       r_C;
  logic [63:0]      r_Cdata;
  logic             r_W;

  logic w_aluWrite;
  logic w_memZero;
  logic w_maskA;
  logic w_maskB;
  logic w_push;
  logic w_pushLive;
  logic w_hasEntry;
  logic w_pop;
  logic w_headLive;
  logic w_hitA;
  logic w_hitB;

  // Zero-register handling: an ALU result to XZR neither writes nor kills
  // older loads, a load to XZR is swallowed as a dead entry, and XZR never
  // reports a hazard.
`ifdef WB_ZERO_REG_EN
  assign w_aluWrite = aluValid && (aluReg != 5'd31);
  assign w_memZero  = (memReg == 5'd31);
  assign w_maskA    = (A == 5'd31);
  assign w_maskB    = (B == 5'd31);
`else
  assign w_aluWrite = aluValid;
  assign w_memZero  = 1'b0;
  assign w_maskA    = 1'b0;
  assign w_maskB    = 1'b0;
`endif

  // memReady looks only at the registered count, so a pop in the same cycle
  // never opens a slot early.
  assign memReady   = !RST && (r_count < FULL);
  assign w_push     = memValid && memReady;

  // A load arriving together with an ALU result to the same register is the
  // older of the two, so it is born dead.
  assign w_pushLive = !w_memZero && !(w_aluWrite && (memReg == aluReg));

  assign w_hasEntry = (r_count != '0);
  assign w_pop      = !aluValid && w_hasEntry;
  assign w_headLive = r_live[r_head];

  // Write-port arbitration, FIFO pointers, occupancy and live bits. The ALU
  // owns the port whenever it is valid; otherwise the head is drained, and a
  // dead head burns one cycle with W low. Live bits are cleared on pop so
  // that only occupied entries can raise a hazard.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_W     <= 1'b0;
      r_C     <= '0;
      r_Cdata <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_live  <= '0;
    end else begin
      if (aluValid) begin
        r_W <= w_aluWrite;
        if (w_aluWrite) begin
          r_C     <= aluReg;
          r_Cdata <= aluData;
        end
      end else if (w_hasEntry) begin
        r_W <= w_headLive;
        if (w_headLive) begin
          r_C     <= r_reg[r_head];
          r_Cdata <= r_data[r_head];
        end
      end else begin
        r_W <= 1'b0;
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (w_aluWrite && (r_reg[i] == aluReg)) begin
          r_live[i] <= 1'b0;
        end
      end

      if (w_pop) begin
        r_live[r_head] <= 1'b0;
        r_head         <= r_head + PW'(1);
      end

      if (w_push) begin
        r_live[r_tail] <= w_pushLive;
        r_tail         <= r_tail + PW'(1);
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Payload storage needs no reset; an entry is only meaningful while it is
  // counted and live.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_reg[r_tail]  <= memReg;
      r_data[r_tail] <= memData;
    end
  end

  // Scan the queue for live writes to either read address.
  always_comb begin
    w_hitA = 1'b0;
    w_hitB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_reg[i] == A)) begin
        w_hitA = 1'b1;
      end
      if (r_live[i] && (r_reg[i] == B)) begin
        w_hitB = 1'b1;
      end
    end
  end

  // The registered write still counts as pending until the bank commits it.
  assign pendA = !w_maskA && (w_hitA || (r_W && (r_C == A)));
  assign pendB = !w_maskB && (w_hitB || (r_W && (r_C == B)));

  assign C     = r_C;
  assign Cdata = r_Cdata;
  assign W     = r_W;

endmodule
